dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single data-memory port between the mips core and one auxiliary
//   requester, such as a debug loader or display fetch engine.
//   The memory reads combinationally, so each cycle has exactly one owner.
//   The CPU has priority. A starvation counter forces one aux cycle after
//   AUX_MAX_WAIT denied cycles and stalls the core through cpu_stall.
//   Top level gates it into the core: mips.enable = enable & ~cpu_stall.
// PARAMETERS
//   Abits        32  address width on all ports
//   Dbits        32  data width on all ports
//   AUX_MAX_WAIT 4   consecutive denied aux cycles before a forced grant (>=1)
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high
//   cpu_rd      in   1      core load this cycle (from lw decode)
//   cpu_wr      in   1      core store this cycle (mips.mem_wr)
//   cpu_addr    in   Abits  core address (mips.mem_addr)
//   cpu_wdata   in   Dbits  core store data
//   cpu_rdata   out  Dbits  core load data (mips.mem_readdata)
//   cpu_stall   out  1      1 = core must hold this cycle
//   aux_req     in   1      aux access request; held until aux_gnt
//   aux_wr      in   1      1 = aux store, 0 = aux load
//   aux_addr    in   Abits  aux address
//   aux_wdata   in   Dbits  aux store data
//   aux_gnt     out  1      aux access performed this cycle
//   aux_rvalid  out  1      registered: aux_rdata holds data from last granted load
//   aux_rdata   out  Dbits  registered aux load data
//   mem_wr      out  1      memory write enable
//   mem_addr    out  Abits  memory address
//   mem_wdata   out  Dbits  memory write data
//   mem_rdata   in   Dbits  memory combinational read data
// BEHAVIOUR
//   - State register st, two states:
//     CPU = normal operation.
//     FORCE = one-cycle aux slot; core is stalled.
//     Reset value: CPU.
//   - cpu_act = cpu_rd | cpu_wr.
//   - aux_gnt = aux_req & (st==FORCE | ~cpu_act)   [combinational]
//   - cpu_stall = (st==FORCE)   [combinational off state; no input dependence]
//   - Owner this cycle is aux when aux_gnt=1, otherwise cpu:
//     mem_addr / mem_wdata come from the owner.
//     mem_wr = aux_gnt ? aux_wr : (cpu_wr & ~cpu_stall)
//   - cpu_rdata = mem_rdata at all times. It is meaningless while cpu_stall=1.
//   - Core writes are never performed in FORCE, even if cpu_wr is high.
//   - wait_cnt: $clog2(AUX_MAX_WAIT+1) bits, reset value 0.
//     aux_req & ~aux_gnt   : wait_cnt <= wait_cnt+1
//     aux_gnt | ~aux_req   : wait_cnt <= 0
//   - Transitions:
//     CPU -> FORCE when aux_req & ~aux_gnt & wait_cnt==AUX_MAX_WAIT-1
//     FORCE -> CPU always, after exactly one cycle
//     In FORCE, aux_req is guaranteed high by protocol. If it is low, FORCE
//     still lasts one cycle, nothing is granted, and mem_wr=0.
//   - Aux read return. On a clock edge where aux_gnt & ~aux_wr:
//     aux_rdata <= mem_rdata; aux_rvalid <= 1.
//     Otherwise aux_rvalid <= 0 and aux_rdata holds.
//     Latency: 1 cycle from the grant to valid data.
//   - Back-to-back aux grants are allowed whenever the core is idle.
//     Each granted load produces its own rvalid pulse.
//   - Worst-case aux wait: AUX_MAX_WAIT cycles.
//     Worst-case core loss: 1 stall cycle per AUX_MAX_WAIT+1 cycles.
//   - Async reset mid-operation:
//     st=CPU, wait_cnt=0, aux_rvalid=0, aux_rdata=0.
//     An in-flight aux load gets no rvalid. Aux must re-request.
//   - Reset values of outputs:
//     cpu_stall=0, aux_rvalid=0, aux_rdata=0.
//     aux_gnt / mem_* follow the combinational rules above with st=CPU.
//   - No X propagation: the owner mux defaults to cpu when aux_req=0.
// TESTING
//   1. Core idle, aux load addr 0x100 (mem holds 0xDEADBEEF):
//      aux_gnt same cycle; next cycle aux_rvalid=1, aux_rdata=0xDEADBEEF;
//      cpu_stall never set.
//   2. cpu_rd=1 continuously, aux_req=1 from cycle 0, MAX_WAIT=4:
//      gnt=0 in cycles 0-3; cycle 4 st=FORCE, cpu_stall=1, aux_gnt=1;
//      cycle 5 cpu_stall=0.
//   3. FORCE cycle with cpu_wr=1 (addr 0x20) and aux store 0x55 to 0x40:
//      mem_wr=1, mem_addr=0x40; mem[0x20] unchanged.
//   4. Core busy 2 cycles, then idle with aux still requesting:
//      grant on cycle 2 with no stall; wait_cnt back to 0.
//   5. Assert reset asynchronously mid-FORCE, just after an aux load grant:
//      cpu_stall drops immediately; aux_rvalid stays 0; st=CPU after release.
//   6. Core idle, aux issues 3 back-to-back loads to 0x0, 0x4, 0x8:
//      3 consecutive rvalid pulses with the matching data, in order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the core owns the port by default, and an auxiliary
// requester uses idle cycles or a forced one-cycle slot after a bounded wait.
module dmem_arbiter #(
  parameter int Abits        = 32,
  parameter int Dbits        = 32,
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [Abits-1:0] cpu_addr,
  input  logic [Dbits-1:0] cpu_wdata,
  output logic [Dbits-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             aux_req,
  input  logic             aux_wr,
  input  logic [Abits-1:0] aux_addr,
  input  logic [Dbits-1:0] aux_wdata,
  output logic             aux_gnt,
  output logic             aux_rvalid,
  output logic [Dbits-1:0] aux_rdata,
  output logic             mem_wr,
  output logic [Abits-1:0] mem_addr,
  output logic [Dbits-1:0] mem_wdata,
  input  logic [Dbits-1:0] mem_rdata
);

  localparam int CW = $clog2(AUX_MAX_WAIT + 1);
  localparam logic [CW-1:0] WaitLast = CW'(AUX_MAX_WAIT - 1);

  typedef enum logic {
    ST_CPU,
    ST_FORCE
  } state_e;

  state_e           st_q, st_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             aux_rvalid_q, aux_rvalid_d;
  logic [Dbits-1:0] aux_rdata_q, aux_rdata_d;
  logic             cpu_act;

  // Owner selection; the core is the owner whenever aux is not granted.
  always_comb begin
    cpu_act   = cpu_rd | cpu_wr;
    cpu_stall = (st_q == ST_FORCE);
    aux_gnt   = aux_req & (cpu_stall | ~cpu_act);
    cpu_rdata = mem_rdata;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr    = cpu_wr & ~cpu_stall;
    if (aux_gnt) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_wr    = aux_wr;
    end
  end

  always_comb begin
    st_d         = ST_CPU;
    wait_cnt_d   = '0;
    aux_rvalid_d = aux_gnt & ~aux_wr;
    aux_rdata_d  = aux_rdata_q;
    if (aux_req && !aux_gnt) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
      if (st_q == ST_CPU && wait_cnt_q == WaitLast) begin
        st_d = ST_FORCE;
      end
    end
    if (aux_rvalid_d) begin
      aux_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= ST_CPU;
      wait_cnt_q   <= '0;
      aux_rvalid_q <= 1'b0;
      aux_rdata_q  <= '0;
    end else begin
      st_q         <= st_d;
      wait_cnt_q   <= wait_cnt_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

  assign aux_rvalid = aux_rvalid_q;
  assign aux_rdata  = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a word memory model behind the port and a
// queue of expected aux load data popped whenever aux_rvalid is seen.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuRd, cpuWr, auxReq, auxWr;
  logic [31:0] cpuAddr, cpuWdata, auxAddr, auxWdata;
  logic [31:0] cpuRdata, auxRdata, memAddr, memWdata, memRdata;
  logic        cpuStall, auxGnt, auxRvalid, memWr;

  logic [31:0] mem [1024];
  logic [31:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          rvalidSeen = 0;

  always #5 clk = ~clk;

  assign memRdata = mem[memAddr[11:2]];

  dmem_arbiter #(.Abits(32), .Dbits(32), .AUX_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpuRd), .cpu_wr(cpuWr), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata), .cpu_stall(cpuStall),
    .aux_req(auxReq), .aux_wr(auxWr), .aux_addr(auxAddr), .aux_wdata(auxWdata),
    .aux_gnt(auxGnt), .aux_rvalid(auxRvalid), .aux_rdata(auxRdata),
    .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] cAddr,
                               input logic [31:0] cData, input logic req, input logic aWr,
                               input logic [31:0] aAddr, input logic [31:0] aData);
    cpuRd    = rd;
    cpuWr    = wr;
    cpuAddr  = cAddr;
    cpuWdata = cData;
    auxReq   = req;
    auxWr    = aWr;
    auxAddr  = aAddr;
    auxWdata = aData;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]        = 32'h1111_1111;
    mem[1]        = 32'h2222_2222;
    mem[2]        = 32'h3333_3333;
    mem[32'h20/4] = 32'hA5A5_A5A5;
    mem[32'h40/4] = 32'h0;
    mem[32'h100/4] = 32'hDEAD_BEEF;
    mem[32'h104/4] = 32'hCAFE_0001;

    fork
      forever begin
        @(posedge clk);
        if (memWr === 1'b1) mem[memAddr[11:2]] = memWdata;
      end
      forever begin
        @(negedge clk);
        if (auxRvalid === 1'b1) begin
          rvalidSeen++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rvalid: got rdata 0x%08h, expected no rvalid", auxRdata);
          end else begin
            checkOutput("aux_rdata", auxRdata, expQ.pop_front());
          end
        end
      end
      begin
        // Reset state
        @(negedge clk);
        checkOutput("rst_stall", 32'(cpuStall), 0);
        checkOutput("rst_rvalid", 32'(auxRvalid), 0);
        checkOutput("rst_rdata", auxRdata, 0);
        checkOutput("rst_gnt", 32'(auxGnt), 0);
        nextCycle();
        reset = 1'b0;

        // Idle core, single aux load
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("t1_gnt", 32'(auxGnt), 1);
        checkOutput("t1_stall", 32'(cpuStall), 0);
        checkOutput("t1_addr", memAddr, 32'h100);
        checkOutput("t1_memwr", 32'(memWr), 0);
        expQ.push_back(32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t1_stall_after", 32'(cpuStall), 0);
        checkOutput("t1_gnt_after", 32'(auxGnt), 0);
        nextCycle();

        // Busy core starves aux until the forced slot
        applyStimulus(1, 0, 32'h8, 32'h0, 1, 0, 32'h104, 32'h0);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checkOutput("t2_gnt_denied", 32'(auxGnt), 0);
          checkOutput("t2_stall_denied", 32'(cpuStall), 0);
          checkOutput("t2_addr_cpu", memAddr, 32'h8);
          checkOutput("t2_cpu_rdata", cpuRdata, 32'h3333_3333);
          nextCycle();
        end
        @(negedge clk);
        checkOutput("t2_force_stall", 32'(cpuStall), 1);
        checkOutput("t2_force_gnt", 32'(auxGnt), 1);
        checkOutput("t2_force_addr", memAddr, 32'h104);
        expQ.push_back(32'hCAFE_0001);
        nextCycle();
        applyStimulus(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2_stall_release", 32'(cpuStall), 0);
        nextCycle();

        // Forced aux store while the core attempts a store
        applyStimulus(1, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h55);
        for (int c = 0; c < 4; c++) nextCycle();
        applyStimulus(0, 1, 32'h20, 32'h7777_7777, 1, 1, 32'h40, 32'h55);
        @(negedge clk);
        checkOutput("t3_stall", 32'(cpuStall), 1);
        checkOutput("t3_memwr", 32'(memWr), 1);
        checkOutput("t3_addr", memAddr, 32'h40);
        checkOutput("t3_wdata", memWdata, 32'h55);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t3_mem20", mem[32'h20/4], 32'hA5A5_A5A5);
        checkOutput("t3_mem40", mem[32'h40/4], 32'h55);
        nextCycle();

        // Core busy two cycles, then idle grant; wait count restarts from zero
        applyStimulus(1, 0, 32'h8, 32'h0, 1, 0, 32'h0, 32'h0);
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          checkOutput("t4_gnt_busy", 32'(auxGnt), 0);
          nextCycle();
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t4_gnt_idle", 32'(auxGnt), 1);
        checkOutput("t4_stall_idle", 32'(cpuStall), 0);
        expQ.push_back(32'h1111_1111);
        nextCycle();
        applyStimulus(1, 0, 32'h8, 32'h0, 1, 0, 32'h4, 32'h0);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checkOutput("t4_no_early_force", 32'(cpuStall), 0);
          checkOutput("t4_gnt_denied", 32'(auxGnt), 0);
          nextCycle();
        end
        @(negedge clk);
        checkOutput("t4_force_stall", 32'(cpuStall), 1);
        checkOutput("t4_force_gnt", 32'(auxGnt), 1);
        expQ.push_back(32'h2222_2222);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        nextCycle();

        // Asynchronous reset right after a forced load grant
        applyStimulus(1, 0, 32'h8, 32'h0, 1, 0, 32'h100, 32'h0);
        for (int c = 0; c < 4; c++) nextCycle();
        @(negedge clk);
        checkOutput("t5_force_stall", 32'(cpuStall), 1);
        checkOutput("t5_force_gnt", 32'(auxGnt), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5_stall_async", 32'(cpuStall), 0);
        checkOutput("t5_rdata_async", auxRdata, 0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("t5_rvalid_reset", 32'(auxRvalid), 0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1, 0, 32'h8, 32'h0, 1, 0, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("t5_stall_after", 32'(cpuStall), 0);
        checkOutput("t5_gnt_after", 32'(auxGnt), 0);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        nextCycle();

        // Back-to-back idle loads
        for (int k = 0; k < 3; k++) begin
          applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'(k * 4), 32'h0);
          @(negedge clk);
          checkOutput("t6_gnt", 32'(auxGnt), 1);
          checkOutput("t6_addr", memAddr, 32'(k * 4));
          expQ.push_back(mem[k]);
          nextCycle();
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        @(negedge clk);
      end
    join_any
    disable fork;

    checkOutput("queue_empty", 32'(expQ.size()), 0);
    checkOutput("rvalid_count", 32'(rvalidSeen), 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
